// File: rtl/mc_control_fsm_if.sv
// Control-unit bus: instruction fields and flags in, datapath controls and debug state out.
interface mc_control_fsm_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    output Op, Funct, Zero, mem_ready,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
    input  ALUControl, PCSrc, PCEn, illegal, state_o
  );

  modport slave (
    input  Op, Funct, Zero, mem_ready,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
    output ALUControl, PCSrc, PCEn, illegal, state_o
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control FSM (Moore). Define MEM_WAIT_EN to stall FETCH, MEMRD and
// MEMWR on mem_ready; otherwise mem_ready is ignored.
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input logic              clk,
  input logic              rst,
  mc_control_fsm_if.slave  bus
);

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StExecute = 4'd7,
    StAluWb   = 4'd8,
    StBranch  = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11,
    StJump    = 4'd12
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   pc_write, branch;
  logic   mem_go;

`ifdef MEM_WAIT_EN
  assign mem_go = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_go = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    illegal_d      = illegal_q;
    pc_write       = 1'b0;
    branch         = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = AluAnd;
    bus.PCSrc      = 2'b00;

    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        // PC increment and IR load happen only on the cycle memory delivers the word.
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = AluAdd;
        bus.IRWrite    = mem_go;
        pc_write       = mem_go;
        state_d        = mem_go ? StDecode : StFetch;
      end
      StDecode: begin
        bus.ALUSrcB    = 2'b11;
        bus.ALUControl = AluAdd;
        case (bus.Op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExecute;
          OP_BEQ:       state_d = StBranch;
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJump;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = 2'b10;
        bus.ALUControl = AluAdd;
        state_d        = (bus.Op == OP_LW) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        bus.IorD = 1'b1;
        state_d  = mem_go ? StMemWb : StMemRd;
      end
      StMemWb: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
        state_d      = StFetch;
      end
      StMemWr: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        state_d      = mem_go ? StFetch : StMemWr;
      end
      StExecute: begin
        bus.ALUSrcA = 1'b1;
        case (bus.Funct)
          6'b100010: bus.ALUControl = AluSub;
          6'b100100: bus.ALUControl = AluAnd;
          6'b100101: bus.ALUControl = AluOr;
          6'b101010: bus.ALUControl = AluSlt;
          default:   bus.ALUControl = AluAdd;
        endcase
        state_d = StAluWb;
      end
      StAluWb: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
        state_d      = StFetch;
      end
      StBranch: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = AluSub;
        bus.PCSrc      = 2'b01;
        branch         = 1'b1;
        state_d        = StFetch;
      end
      StAddiEx: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = 2'b10;
        bus.ALUControl = AluAdd;
        state_d        = StAddiWb;
      end
      StAddiWb: begin
        bus.RegWrite = 1'b1;
        state_d      = StFetch;
      end
      StJump: begin
        bus.PCSrc = 2'b10;
        pc_write  = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  assign bus.PCEn    = pc_write | (branch & bus.Zero);
  assign bus.illegal = illegal_q;
  assign bus.state_o = state_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control unit for the multi-cycle MIPS datapath.
- Sequences every instruction through fetch, decode, execute, memory and writeback states.
- Drives the register file's RegWrite and all datapath mux, enable and ALU-control signals.
- Sits directly upstream of the register file, ALU and memory; consumes opcode/funct from the instruction register.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_ADDI, 6'b001000, add-immediate opcode
- OP_J, 6'b000010, jump opcode

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- Op  input  6  instr[31:26] from instruction register
- Funct  input  6  instr[5:0]
- Zero  input  1  ALU zero flag
- mem_ready  input  1  memory handshake; used only with MEM_WAIT_EN
- IorD  output  1  memory address: 0=PC, 1=ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load enable
- RegDst  output  1  A3 select: 0=rt, 1=rd
- MemtoReg  output  1  WD3 select: 0=ALUOut, 1=Data
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  0=PC, 1=A
- ALUSrcB  output  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
- ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
- PCEn  output  1  PC load = PCWrite | (Branch & Zero)
- illegal  output  1  sticky unsupported-opcode flag
- state_o  output  4  current state encoding, for debug

Behaviour:
- Interface fixed: one clock clk; reset rst is asynchronous, active-high.
- Encoding is Moore: all outputs decode from the state register only, except PCEn (uses Zero) and ALUControl in EXECUTE (uses Funct).
- Reset: state=IDLE (0); every output 0; illegal=0. IDLE→FETCH unconditionally on the first edge after release.
- States and asserted outputs (unlisted outputs are 0):
  - FETCH(1): IorD=0, IRWrite, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00, PCWrite. →DECODE.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut).
    - lw/sw→MEMADR; R→EXECUTE; beq→BRANCH; addi→ADDIEX; j→JUMP.
    - Any other opcode→FETCH; illegal set to 1, cleared only by rst.
  - MEMADR(3): ALUSrcA=1, ALUSrcB=10, add. lw→MEMRD; sw→MEMWR.
  - MEMRD(4): IorD=1. →MEMWB.
  - MEMWB(5): RegDst=0, MemtoReg=1, RegWrite. →FETCH.
  - MEMWR(6): IorD=1, MemWrite. →FETCH.
  - EXECUTE(7): ALUSrcA=1, ALUSrcB=00, ALUControl from Funct. →ALUWB.
    - Funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
    - Unknown Funct gives add; illegal is not set.
  - ALUWB(8): RegDst=1, MemtoReg=0, RegWrite. →FETCH.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch. →FETCH.
  - ADDIEX(10): ALUSrcA=1, ALUSrcB=10, add. →ADDIWB.
  - ADDIWB(11): RegDst=0, MemtoReg=0, RegWrite. →FETCH.
  - JUMP(12): PCSrc=10, PCWrite. →FETCH.
  - Unused encodings 13–15: →FETCH, no outputs asserted.
- Instruction latency in cycles (FETCH to FETCH): lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- RegWrite is asserted for exactly one cycle per writing instruction.
- The register file samples operands every edge, so A and B are valid in MEMADR, EXECUTE and BRANCH.
- Reset mid-instruction returns immediately (async) to IDLE with all outputs 0; no partial writeback occurs.

Optional Feature:
- Macro: MEM_WAIT_EN.
- When defined:
  - FETCH, MEMRD and MEMWR hold their state and outputs while mem_ready=0 and advance on the edge where mem_ready=1.
  - In FETCH, PCWrite and IRWrite assert only in the mem_ready=1 cycle.
- When undefined: mem_ready is ignored; every memory state lasts exactly one cycle.

Test Plan:
- Reset: rst=1 asynchronously mid-MEMRD → same cycle, state_o=0 and all outputs 0; after release, IDLE then FETCH with IRWrite=1 and ALUSrcB=01.
- lw: Op=100011 → states 1,2,3,4,5,1; RegWrite=1 only in MEMWB with MemtoReg=1, RegDst=0.
- R-type: Op=0, Funct=100010 → EXECUTE with ALUControl=110; ALUWB with RegDst=1, RegWrite=1; 4 cycles total.
- beq: Zero=1 in BRANCH → PCEn=1, PCSrc=01. Zero=0 → PCEn=0. Both return to FETCH after 3 cycles.
- Illegal: Op=111111 → DECODE→FETCH, illegal=1 and stays 1 across the following sw; cleared only by rst.
- MEM_WAIT_EN: mem_ready low for 3 cycles in FETCH → 4 FETCH cycles, PCWrite/IRWrite high only in the 4th; sw with 2 wait cycles takes 6 cycles total.
